pc_next_sequencer: RTL and testbench

- Parametrised next-address/program-counter unit for the microprocessor fetch path; successor to the 2-way sequential/jump address select.
- Chooses among a sequential increment and NSRC-1 target inputs, and registers the result as the PC.
- Adds stall, a circular return-address stack (RAS) for call/return, and sticky stack-error flags.
- Sits between the control unit (select, call, ret, stall) and instruction memory address.

---
 rtl/pc_next_sequencer_pkg.sv | 18 +
 rtl/return_addr_stack.sv | 70 +++++++
 rtl/pc_next_sequencer.sv | 93 +++++++++
 tb/tb_pc_next_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_next_sequencer_pkg.sv
// Shared constants and helpers for the PC sequencer and other fetch/DMA address logic.
package pc_next_sequencer_pkg;

    localparam int unsigned SRC_SEQ              = 0;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEFAULT_STEP         = 4;

    // Width needed to index 'value' items; never less than 1 so ports stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push while full silently overwrites the oldest entry.
module return_addr_stack
    import pc_next_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             ovf_pulse,
    output logic             unf_pulse
);

    localparam int unsigned PTR_W = clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // wr_ptr names the next free slot; the top of stack sits just below it.
    assign top_ptr   = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - 1'b1;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign ovf_pulse = do_push && full;
    assign unf_pulse = pop && empty;
    assign dout      = entries[top_ptr];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - 1'b1;
        end else if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (!full) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            entries[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_next_sequencer.sv
// Next-PC selection (sequential / targets / return stack) with stall and sticky stack-error flags.
module pc_next_sequencer
    import pc_next_sequencer_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       NSRC         = 4,
    parameter int unsigned       STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [clog2(NSRC)-1:0]      sel,
    input  logic [(NSRC-1)*WIDTH-1:0]   targets,
    input  logic                        call,
    input  logic                        ret,
    output logic [WIDTH-1:0]            pc,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam int unsigned      SEL_W    = clog2(NSRC);
    localparam logic [SEL_W:0]   NSRC_EXT = (SEL_W + 1)'(NSRC);

    logic [WIDTH-1:0] pc_q, pc_d, seq_pc, target, ras_top;
    logic             sel_valid, push, pop;
    logic             ovf_pulse, unf_pulse;
    logic             ovf_q, unf_q;

    assign seq_pc    = pc_q + WIDTH'(STEP);
    assign sel_valid = (sel != SEL_W'(SRC_SEQ)) && ({1'b0, sel} < NSRC_EXT);
    assign pop       = !stall && ret;
    assign push      = !stall && !ret && call && sel_valid;

    always_comb begin
        target = '0;
        for (int k = 1; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                target = targets[(k-1)*WIDTH +: WIDTH];
            end
        end
    end

    return_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (seq_pc),
        .dout      (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse)
    );

    // A return on an empty stack falls through to the sequential address.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (ret) begin
                pc_d = ras_empty ? seq_pc : ras_top;
            end else if (sel_valid) begin
                pc_d = target;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_q | ovf_pulse;
            unf_q <= unf_q | unf_pulse;
        end
    end

    assign pc            = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Directed vector bench for pc_next_sequencer: default build plus a wrap/NSRC=3 build.
module tb_pc_next_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (WIDTH=32, NSRC=4, STEP=4, RESET_VECTOR=0, RAS_DEPTH=4)
    logic        reset_a, stall_a, call_a, ret_a;
    logic [1:0]  sel_a;
    logic [95:0] targets_a;
    logic [31:0] pc_a;
    logic        emp_a, full_a, ovf_a, unf_a;

    pc_next_sequencer u_dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .stall         (stall_a),
        .sel           (sel_a),
        .targets       (targets_a),
        .call          (call_a),
        .ret           (ret_a),
        .pc            (pc_a),
        .ras_empty     (emp_a),
        .ras_full      (full_a),
        .ras_overflow  (ovf_a),
        .ras_underflow (unf_a)
    );

    // Instance B: three sources and a reset vector near the top of the address space
    logic        reset_b, stall_b, call_b, ret_b;
    logic [1:0]  sel_b;
    logic [63:0] targets_b;
    logic [31:0] pc_b;
    logic        emp_b, full_b, ovf_b, unf_b;

    pc_next_sequencer #(
        .NSRC         (3),
        .RESET_VECTOR (32'hFFFF_FFF8)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .stall         (stall_b),
        .sel           (sel_b),
        .targets       (targets_b),
        .call          (call_b),
        .ret           (ret_b),
        .pc            (pc_b),
        .ras_empty     (emp_b),
        .ras_full      (full_b),
        .ras_overflow  (ovf_b),
        .ras_underflow (unf_b)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        call;
        logic        ret;
        logic [31:0] pc;
        logic        emp;
        logic        full;
        logic        ovf;
        logic        unf;
    } vec_t;

    int passes = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] sel,
                                input logic [31:0] tgt, input logic call, input logic ret,
                                input logic [31:0] pc, input logic emp, input logic full,
                                input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.stl = stl; v.sel = sel; v.tgt = tgt; v.call = call; v.ret = ret;
        v.pc = pc; v.emp = emp; v.full = full; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Selected source gets tgt; the others carry junk so a wrong mux leg is visible.
    task automatic apply_a(input string tag, input vec_t v);
        reset_a = v.rst;
        stall_a = v.stl;
        sel_a   = v.sel;
        call_a  = v.call;
        ret_a   = v.ret;
        for (int k = 1; k < 4; k++) begin
            targets_a[(k-1)*32 +: 32] = (v.sel == 2'(k)) ? v.tgt : 32'hBAD0_0000 + 32'(k);
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"},    pc_a,   v.pc);
        check({tag, ".empty"}, emp_a,  v.emp);
        check({tag, ".full"},  full_a, v.full);
        check({tag, ".ovf"},   ovf_a,  v.ovf);
        check({tag, ".unf"},   unf_a,  v.unf);
    endtask

    task automatic step_b(input string tag, input logic rst, input logic [1:0] sel,
                          input logic [31:0] t1, input logic [31:0] t2, input logic call,
                          input logic [31:0] exp_pc, input logic exp_emp);
        reset_b   = rst;
        sel_b     = sel;
        call_b    = call;
        targets_b = {t2, t1};
        @(posedge clk);
        #1;
        check({tag, ".pc"},    pc_b,  exp_pc);
        check({tag, ".empty"}, emp_b, exp_emp);
    endtask

    vec_t vecs [20];

    initial begin
        reset_a = 1'b1; stall_a = 1'b0; sel_a = '0; targets_a = '0; call_a = 1'b0; ret_a = 1'b0;
        reset_b = 1'b1; stall_b = 1'b0; sel_b = '0; targets_b = '0; call_b = 1'b0; ret_b = 1'b0;

        //           rst stl sel tgt            call ret pc             emp full ovf unf
        vecs[0]  = mk(1, 0, 2, 32'h0000_1234, 1, 1, 32'h0000_0000, 1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 32'h0000_5678, 1, 0, 32'h0000_0000, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0000_0000, 0, 0, 32'h0000_0004, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 32'h0000_0000, 0, 0, 32'h0000_0008, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0000_0000, 0, 0, 32'h0000_000C, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 3, 32'h0000_0100, 0, 0, 32'h0000_0100, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 2, 32'h0000_2000, 0, 0, 32'h0000_2000, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 32'h0000_3000, 0, 0, 32'h0000_3000, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 32'h0000_0010, 0, 0, 32'h0000_0010, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 32'h0000_0100, 1, 0, 32'h0000_0100, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 32'h0000_0200, 1, 0, 32'h0000_0200, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 2, 32'h0000_0300, 1, 0, 32'h0000_0300, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 2, 32'h0000_0400, 1, 0, 32'h0000_0400, 0, 1, 0, 0);
        vecs[13] = mk(0, 0, 3, 32'h0000_0500, 1, 0, 32'h0000_0500, 0, 1, 1, 0);
        vecs[14] = mk(0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0404, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0304, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0204, 0, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0104, 1, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0108, 1, 0, 1, 1);
        vecs[19] = mk(0, 0, 0, 32'h0000_0000, 1, 0, 32'h0000_010C, 1, 0, 1, 1);

        for (int i = 0; i < 20; i++) begin
            apply_a($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset beats stall and clears sticky flags; then stall must freeze call/ret.
        apply_a("rst_over_stall", mk(1, 1, 0, 32'h0, 0, 1, 32'h0000_0000, 1, 0, 0, 0));
        apply_a("jump_40",        mk(0, 0, 1, 32'h40, 0, 0, 32'h0000_0040, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            apply_a($sformatf("stall_call%0d", i),
                    mk(0, 1, 1, 32'h80, 1, 0, 32'h0000_0040, 1, 0, 0, 0));
        end
        apply_a("stall_ret",      mk(0, 1, 0, 32'h0, 0, 1, 32'h0000_0040, 1, 0, 0, 0));
        apply_a("release_call",   mk(0, 0, 1, 32'h80, 1, 0, 32'h0000_0080, 0, 0, 0, 0));
        // call+ret together: return wins and nothing is pushed
        apply_a("call_and_ret",   mk(0, 0, 1, 32'h900, 1, 1, 32'h0000_0044, 1, 0, 0, 0));
        apply_a("ret_after",      mk(0, 0, 0, 32'h0, 0, 1, 32'h0000_0048, 1, 0, 0, 1));

        stall_a = 1'b1;
        ret_a   = 1'b0;
        call_a  = 1'b0;

        step_b("b_reset",   1, 0, 32'h0,    32'h0,    0, 32'hFFFF_FFF8, 1);
        step_b("b_seq0",    0, 0, 32'h0,    32'h0,    0, 32'hFFFF_FFFC, 1);
        step_b("b_wrap",    0, 0, 32'h0,    32'h0,    0, 32'h0000_0000, 1);
        step_b("b_invalid", 0, 3, 32'h1111, 32'h2222, 1, 32'h0000_0004, 1);
        step_b("b_src2",    0, 2, 32'h1111, 32'h1234, 0, 32'h0000_1234, 1);
        step_b("b_src1",    0, 1, 32'h5678, 32'h2222, 0, 32'h0000_5678, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
